flop_window_max: RTL

- Streaming reduction stage that sits directly downstream of flop_greaterthan.
- Accepts a stream of 13-bit flop values and instantiates flop_greaterthan to compare each new sample against the running maximum.
- Emits the maximum and its position for every fixed-size window of samples.
- Feeds the display/readout logic with one result per window over a valid/ready handshake.

---
 rtl/flop_window_max.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/flop_window_max.sv
// Windowed maximum over a stream of 13-bit sign/magnitude flop samples.
// Reports the winning value and its position once per WINDOW samples over valid/ready.

module flop_greaterthan (
  input  logic [12:0] first,
  input  logic [12:0] second,
  output logic        is_greater
);
  logic        sign_a_s;
  logic        sign_b_s;
  logic [11:0] mag_a_s;
  logic [11:0] mag_b_s;
  logic        both_zero_s;

  assign sign_a_s    = first[12];
  assign sign_b_s    = second[12];
  assign mag_a_s     = first[11:0];
  assign mag_b_s     = second[11:0];
  assign both_zero_s = (mag_a_s == 12'd0) && (mag_b_s == 12'd0);

  // Strict ordering; +0 and -0 are equal, negatives order by smaller magnitude
  always_comb begin
    is_greater = 1'b0;
    if (both_zero_s) begin
      is_greater = 1'b0;
    end else if (sign_a_s != sign_b_s) begin
      is_greater = ~sign_a_s;
    end else if (sign_a_s) begin
      is_greater = (mag_a_s < mag_b_s);
    end else begin
      is_greater = (mag_a_s > mag_b_s);
    end
  end
endmodule

module flop_window_max #(
  parameter int WINDOW = 8,
  parameter int IDXW   = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [12:0]     in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [12:0]     out_max,
  output logic [IDXW-1:0] out_index,
  output logic            busy
);
  typedef enum logic [0:0] {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WINDOW - 1);
  localparam logic [IDXW-1:0] IDX_ZERO = {IDXW{1'b0}};
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  state_t          state_r, state_next_s;
  logic [IDXW-1:0] count_r, count_next_s;
  logic [12:0]     max_r, max_next_s;
  logic [IDXW-1:0] idx_r, idx_next_s;
  logic [12:0]     out_max_r;
  logic [IDXW-1:0] out_index_r;
  logic            in_ready_r, out_valid_r, busy_r;
  logic            accept_s, gt_s, load_out_s;

  flop_greaterthan u_gt (
    .first      (in_data),
    .second     (max_r),
    .is_greater (gt_s)
  );

  assign accept_s  = in_valid & in_ready_r;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_max   = out_max_r;
  assign out_index = out_index_r;
  assign busy      = busy_r;

  // Next-state, running max/index update and window-complete detection
  always_comb begin
    state_next_s = state_r;
    count_next_s = count_r;
    max_next_s   = max_r;
    idx_next_s   = idx_r;
    load_out_s   = 1'b0;
    case (state_r)
      ACCUM: begin
        if (accept_s) begin
          // First sample of a window seeds the max; ties keep the earlier index
          if ((count_r == IDX_ZERO) || gt_s) begin
            max_next_s = in_data;
            idx_next_s = count_r;
          end else begin
            max_next_s = max_r;
          end
          if (count_r == LAST_IDX) begin
            count_next_s = IDX_ZERO;
            state_next_s = HOLD;
            load_out_s   = 1'b1;
          end else begin
            count_next_s = count_r + IDX_ONE;
          end
        end else begin
          count_next_s = count_r;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next_s = ACCUM;
        end else begin
          state_next_s = HOLD;
        end
      end
      default: begin
        state_next_s = ACCUM;
        count_next_s = IDX_ZERO;
      end
    endcase
  end

  // State, accumulator and registered handshake/result outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ACCUM;
      count_r     <= IDX_ZERO;
      max_r       <= 13'd0;
      idx_r       <= IDX_ZERO;
      out_max_r   <= 13'd0;
      out_index_r <= IDX_ZERO;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      count_r     <= count_next_s;
      max_r       <= max_next_s;
      idx_r       <= idx_next_s;
      in_ready_r  <= (state_next_s == ACCUM);
      out_valid_r <= (state_next_s == HOLD);
      busy_r      <= (count_next_s != IDX_ZERO);
      if (load_out_s) begin
        out_max_r   <= max_next_s;
        out_index_r <= idx_next_s;
      end else begin
        out_max_r   <= out_max_r;
        out_index_r <= out_index_r;
      end
    end
  end
endmodule
